ex_reg: RTL
===========

Name: ex_reg

Overview:
- EX/MEM pipeline register of the 32-bit core.
- Captures the ALU result and overflow flag together with the control fields forwarded from ID, and converts signed overflow into a precise exception.
- Handles pipeline stall, flush and interrupt bubbles.
- Its outputs feed the MEM stage and the forwarding network.

Parameters:
- WORD_W, 32, data word width (`WordDataBus`)
- PC_W, 30, word-address width (`WordAddrBus`)
- REG_ADDR_W, 5, GPR address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all outputs this cycle
- flush  in  1  replace incoming instruction with bubble
- int_detect  in  1  interrupt taken; insert bubble
- id_pc  in  PC_W  PC of instruction in EX
- id_en  in  1  instruction in EX is valid
- id_br_flag  in  1  instruction is a branch
- id_mem_op  in  2  memory op (NOP/LDW/STW)
- id_mem_wr_data  in  WORD_W  store data
- id_ctrl_op  in  2  control op (NOP/WRCR/EXRT)
- id_dst_addr  in  REG_ADDR_W  GPR write address
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception code from ID
- alu_out  in  WORD_W  ALU result, same cycle
- alu_of  in  1  ALU signed overflow, same cycle
- ex_pc  out  PC_W  registered PC
- ex_en  out  1  registered valid
- ex_br_flag  out  1  registered branch flag
- ex_mem_op  out  2  registered memory op
- ex_mem_wr_data  out  WORD_W  registered store data
- ex_ctrl_op  out  2  registered control op
- ex_dst_addr  out  REG_ADDR_W  registered destination
- ex_gpr_we_  out  1  registered GPR write enable, active-low
- ex_exp_code  out  3  registered exception code
- ex_out  out  WORD_W  registered ALU result

Behaviour:
- Reset values:
  - All outputs zero, except ex_gpr_we_ = 1 (disabled).
  - ex_mem_op = NOP, ex_ctrl_op = NOP, ex_exp_code = NO_EXP(0).
- Latency: one cycle, input to output. No combinational path from inputs to outputs.
- Per-edge priority (exactly one branch applies):
  1. reset: load reset values.
  2. stall: all outputs hold.
  3. flush or int_detect: load bubble.
     - Bubble fields: ex_en = 0, br_flag = 0, mem_op = NOP, ctrl_op = NOP, dst_addr = 0, gpr_we_ = 1, exp_code = NO_EXP, ex_out = 0, mem_wr_data = 0.
     - ex_pc still loads id_pc.
  4. Overflow trap condition (see below): load overflow record.
     - ex_en = id_en, ex_pc = id_pc, ex_out = alu_out.
     - br_flag = 0, mem_op = NOP, ctrl_op = NOP, gpr_we_ = 1.
     - exp_code = OVERFLOW(3).
  5. Otherwise: load all id_* fields and alu_out unchanged.
- Overflow trap condition: alu_of = 1 AND id_en = 1 AND id_exp_code = NO_EXP.
- An earlier exception from ID always wins over overflow; that code passes through unchanged.
- alu_of with id_en = 0 has no effect; the record is loaded normally.
- stall together with flush: stall wins. Flush must be re-asserted by the hazard unit after the stall releases.
- Reset asserted during stall: reset wins.
- No internal state beyond the output registers. Registers are not mutated except through the branches above.

Optional Feature:
- Macro: EX_OVF_TRAP_EN
- Defined: overflow handled as in priority step 4.
- Undefined:
  - Step 4 is removed and alu_of is ignored (port kept, unused).
  - Signed add/sub wrap silently: result is written to the GPR, and exp_code is always id_exp_code.

Decomposition:
- Shared package/header (cpu.h / isa.h) holds:
  - MEM_OP_NOP/LDW/STW
  - CTRL_OP_NOP/WRCR/EXRT
  - ISA_EXP_NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6
  - Bus-width macros; ENABLE/DISABLE/ENABLE_/DISABLE_
- No sub-module; single always block.
- The upper EX stage instantiates alu and ex_reg side by side.

Test Plan:
- Reset held 2 cycles, then released with id_en=1, id_gpr_we_=0, alu_out=0x0000_1234, id_dst_addr=5 -> during reset ex_gpr_we_=1, ex_en=0; one cycle after release ex_out=0x1234, ex_dst_addr=5, ex_gpr_we_=0, ex_exp_code=0.
- Overflow with EX_OVF_TRAP_EN defined:
  - id_en=1, alu_out=0x8000_0000, alu_of=1, id_mem_op=STW, id_exp_code=0 -> ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=NOP, ex_en=1.
  - Same stimulus with id_exp_code=2 -> ex_exp_code=2.
- Same overflow stimulus, macro undefined -> ex_exp_code=0, ex_gpr_we_=0, ex_out=0x8000_0000.
- stall=1 for 3 cycles while inputs change each cycle -> all outputs frozen at pre-stall values.
  - stall and flush asserted together -> outputs unchanged.
  - flush alone next cycle -> ex_en=0, ex_exp_code=0.
- int_detect=1 with id_en=1, id_pc=0x100, alu_of=1 -> bubble loaded: ex_en=0, ex_pc=0x100, ex_exp_code=0, ex_gpr_we_=1.

Source files
------------

// File: rtl/ex_reg_pkg.sv
// Shared ISA encodings for the EX/MEM pipeline register: memory ops, control ops, exception codes.
package ex_reg_pkg;

  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] MEM_OP_LDW  = 2'd1;
  localparam logic [1:0] MEM_OP_STW  = 2'd2;

  localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/ex_reg.sv
// EX/MEM pipeline register: captures ALU result plus forwarded ID control, handles stall/flush/interrupt.
// Define EX_OVF_TRAP_EN to turn ALU signed overflow into a precise OVERFLOW exception.
module ex_reg
  import ex_reg_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int PC_W       = 30,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic [PC_W-1:0]       id_pc,
  input  logic                  id_en,
  input  logic                  id_br_flag,
  input  logic [1:0]            id_mem_op,
  input  logic [WORD_W-1:0]     id_mem_wr_data,
  input  logic [1:0]            id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [2:0]            id_exp_code,
  input  logic [WORD_W-1:0]     alu_out,
  input  logic                  alu_of,
  output logic [PC_W-1:0]       ex_pc,
  output logic                  ex_en,
  output logic                  ex_br_flag,
  output logic [1:0]            ex_mem_op,
  output logic [WORD_W-1:0]     ex_mem_wr_data,
  output logic [1:0]            ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [2:0]            ex_exp_code,
  output logic [WORD_W-1:0]     ex_out
);

  logic [PC_W-1:0]       pc_q,       pc_d;
  logic                  en_q,       en_d;
  logic                  br_flag_q,  br_flag_d;
  logic [1:0]            mem_op_q,   mem_op_d;
  logic [WORD_W-1:0]     wr_data_q,  wr_data_d;
  logic [1:0]            ctrl_op_q,  ctrl_op_d;
  logic [REG_ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic                  gpr_we_q,   gpr_we_d;
  logic [2:0]            exp_code_q, exp_code_d;
  logic [WORD_W-1:0]     out_q,      out_d;

`ifdef EX_OVF_TRAP_EN
  // An exception already raised in ID outranks overflow; invalid slots never trap.
  logic ovf_trap;
  assign ovf_trap = alu_of && id_en && (id_exp_code == ISA_EXP_NO_EXP);
`else
  logic unused_alu_of;
  assign unused_alu_of = alu_of;
`endif

  always_comb begin
    pc_d       = pc_q;
    en_d       = en_q;
    br_flag_d  = br_flag_q;
    mem_op_d   = mem_op_q;
    wr_data_d  = wr_data_q;
    ctrl_op_d  = ctrl_op_q;
    dst_addr_d = dst_addr_q;
    gpr_we_d   = gpr_we_q;
    exp_code_d = exp_code_q;
    out_d      = out_q;
    if (stall) begin
      // hold
    end else if (flush || int_detect) begin
      // Bubble keeps the PC so the interrupt handler knows where to resume.
      pc_d       = id_pc;
      en_d       = DISABLE;
      br_flag_d  = DISABLE;
      mem_op_d   = MEM_OP_NOP;
      wr_data_d  = '0;
      ctrl_op_d  = CTRL_OP_NOP;
      dst_addr_d = '0;
      gpr_we_d   = DISABLE_;
      exp_code_d = ISA_EXP_NO_EXP;
      out_d      = '0;
`ifdef EX_OVF_TRAP_EN
    end else if (ovf_trap) begin
      pc_d       = id_pc;
      en_d       = id_en;
      br_flag_d  = DISABLE;
      mem_op_d   = MEM_OP_NOP;
      wr_data_d  = id_mem_wr_data;
      ctrl_op_d  = CTRL_OP_NOP;
      dst_addr_d = id_dst_addr;
      gpr_we_d   = DISABLE_;
      exp_code_d = ISA_EXP_OVERFLOW;
      out_d      = alu_out;
`endif
    end else begin
      pc_d       = id_pc;
      en_d       = id_en;
      br_flag_d  = id_br_flag;
      mem_op_d   = id_mem_op;
      wr_data_d  = id_mem_wr_data;
      ctrl_op_d  = id_ctrl_op;
      dst_addr_d = id_dst_addr;
      gpr_we_d   = id_gpr_we_;
      exp_code_d = id_exp_code;
      out_d      = alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      en_q       <= DISABLE;
      br_flag_q  <= DISABLE;
      mem_op_q   <= MEM_OP_NOP;
      wr_data_q  <= '0;
      ctrl_op_q  <= CTRL_OP_NOP;
      dst_addr_q <= '0;
      gpr_we_q   <= DISABLE_;
      exp_code_q <= ISA_EXP_NO_EXP;
      out_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      en_q       <= en_d;
      br_flag_q  <= br_flag_d;
      mem_op_q   <= mem_op_d;
      wr_data_q  <= wr_data_d;
      ctrl_op_q  <= ctrl_op_d;
      dst_addr_q <= dst_addr_d;
      gpr_we_q   <= gpr_we_d;
      exp_code_q <= exp_code_d;
      out_q      <= out_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en          = en_q;
  assign ex_br_flag     = br_flag_q;
  assign ex_mem_op      = mem_op_q;
  assign ex_mem_wr_data = wr_data_q;
  assign ex_ctrl_op     = ctrl_op_q;
  assign ex_dst_addr    = dst_addr_q;
  assign ex_gpr_we_     = gpr_we_q;
  assign ex_exp_code    = exp_code_q;
  assign ex_out         = out_q;

endmodule
